ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 124 ++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage RV32 pipeline plus the EX/MEM register.
//
// Operand forwarding happens here. The EX/MEM (M) stage takes priority over
// writeback (W). Register x0 is never forwarded. The ALU result is used both
// for the M-stage capture and for the branch-equal test. The redirect
// target is always PCE + ImmExtE.
//
// Ports
//   clk, reset           : clock; asynchronous active-high reset
//   *E inputs            : decoded EX-stage bundle (control, operands, PC values)
//   RegWriteW/RdW/ResultW: writeback-stage register write happening this cycle
//   hold                 : memory-side stall; freezes EX/MEM and blocks redirect
//   PCSrcE, PCTargetE    : combinational fetch redirect and its target
//   *M outputs           : registered EX/MEM bundle
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] PCE,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCPlus4E,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        hold,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        MemWriteM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  RdM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] fwd_m;
  logic [31:0] src_a;
  logic [31:0] src_b_fwd;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;

  // A jump-and-link sitting in M produces PC+4, not its ALU result. A load
  // in M still forwards the address: load-use hazards are stalled upstream.
  always_comb begin
    fwd_m = (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;
  end

  always_comb begin
    src_a = rd1E;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      src_a = fwd_m;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      src_a = ResultW;
  end

  always_comb begin
    src_b_fwd = rd2E;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      src_b_fwd = fwd_m;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      src_b_fwd = ResultW;
  end

  always_comb begin
    src_b = ALUSrcE ? ImmExtE : src_b_fwd;
  end

  always_comb begin
    alu_result = 32'd0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      3'b110:  alu_result = src_a << src_b[4:0];
      3'b111:  alu_result = src_a >> src_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    zero      = (alu_result == 32'd0);
    PCTargetE = PCE + ImmExtE;
    // A stalled instruction must not redirect fetch. It redirects once the
    // stall clears, which prevents a duplicate redirect.
    PCSrcE    = ~hold & (JumpE | (BranchE & zero));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      RdM        <= 5'd0;
      PCPlus4M   <= 32'd0;
    end else if (!hold) begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= alu_result;
      WriteDataM <= src_b_fwd;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage.
// It applies a vector table, a set of hand-written multi-cycle sequences, and
// randomized traffic. All results are compared against a behavioural model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] rd1E, rd2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        hold;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .rd1E(rd1E), .rd2E(rd2E), .PCE(PCE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .hold(hold),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the instruction that currently sits in the M stage.
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        alusrc;
    logic [31:0] imm, pce;
    logic        jump, branch;
    logic [31:0] exp_alu;
    logic        exp_pcsrc;
    logic [31:0] exp_tgt;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // The newest pending writer of register rs supplies the value. This is the
  // M-stage instruction if it writes rs, else the W-stage write, else the
  // register file. x0 always reads as the register-file value.
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    if (m_rw && m_rd != 0 && m_rd == rs) return (m_rs == 2'b10) ? m_pc4 : m_alu;
    if (RegWriteW && RdW != 0 && RdW == rs) return ResultW;
    return rf;
  endfunction

  function automatic logic [31:0] alu_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] model_alu();
    logic [31:0] b;
    b = ALUSrcE ? ImmExtE : operand(Rs2E, rd2E);
    return alu_of(ALUControlE, operand(Rs1E, rd1E), b);
  endfunction

  function automatic logic model_pcsrc();
    return !hold && (JumpE || (BranchE && model_alu() == 32'd0));
  endfunction

  task automatic model_clear();
    m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
  endtask

  task automatic clear_in();
    RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUControlE = 0; ALUSrcE = 0; rd1E = 0; rd2E = 0; PCE = 0; Rs1E = 0;
    Rs2E = 0; RdE = 0; ImmExtE = 0; PCPlus4E = 0; RegWriteW = 0; RdW = 0;
    ResultW = 0; hold = 0;
  endtask

  task automatic chk_comb();
    logic [31:0] tgt;
    #1;
    tgt = PCE + ImmExtE;
    chk("pcsrc", 32'(PCSrcE), 32'(model_pcsrc()));
    chk("pctarget", PCTargetE, tgt);
  endtask

  task automatic chk_m();
    chk("regwrite_m", 32'(RegWriteM), 32'(m_rw));
    chk("resultsrc_m", 32'(ResultSrcM), 32'(m_rs));
    chk("memwrite_m", 32'(MemWriteM), 32'(m_mw));
    chk("aluresult_m", ALUResultM, m_alu);
    chk("writedata_m", WriteDataM, m_wd);
    chk("rd_m", 32'(RdM), 32'(m_rd));
    chk("pcplus4_m", PCPlus4M, m_pc4);
  endtask

  // Take one rising edge; the model captures the EX bundle unless the stage is stalled or in reset.
  task automatic tick();
    logic        n_upd;
    logic [31:0] n_alu, n_wd;
    n_upd = !hold && !reset;
    n_alu = model_alu();
    n_wd  = operand(Rs2E, rd2E);
    @(posedge clk);
    #1;
    if (n_upd) begin
      m_rw = RegWriteE; m_rs = ResultSrcE; m_mw = MemWriteE; m_alu = n_alu;
      m_wd = n_wd; m_rd = RdE; m_pc4 = PCPlus4E;
    end
    chk_m();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //               op    a             b             src   imm           pce           j     b     exp_alu       pcsrc tgt
    vt[0]  = '{3'd0, 32'd5,        32'd7,        1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd12,       1'b0, 32'd0};
    vt[1]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd1,        1'b0, 32'd0};
    vt[2]  = '{3'd1, 32'd3,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 32'd0};
    vt[3]  = '{3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'h00F000F0, 1'b0, 32'd0};
    vt[4]  = '{3'd3, 32'hF0000000, 32'h0000000F, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'hF000000F, 1'b0, 32'd0};
    vt[5]  = '{3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'hF0F00F0F, 1'b0, 32'd0};
    vt[6]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd1,        1'b0, 32'd0};
    vt[7]  = '{3'd5, 32'd1,        32'hFFFFFFFF, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 32'd0};
    vt[8]  = '{3'd6, 32'd1,        32'd33,       1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd2,        1'b0, 32'd0};
    vt[9]  = '{3'd7, 32'h80000000, 32'd31,       1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd1,        1'b0, 32'd0};
    vt[10] = '{3'd1, 32'h40,       32'h40,       1'b0, 32'hFFFFFFF8, 32'h100,      1'b0, 1'b1, 32'd0,        1'b1, 32'hF8};
    vt[11] = '{3'd1, 32'h40,       32'h41,       1'b0, 32'hFFFFFFF8, 32'h100,      1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hF8};
    vt[12] = '{3'd0, 32'h20,       32'd0,        1'b1, 32'h10,       32'h1000,     1'b1, 1'b0, 32'h30,       1'b1, 32'h1010};

    // Power-on reset: every M output is held at zero.
    reset = 1;
    clear_in();
    model_clear();
    #3;
    chk_m();
    chk("reset_pcsrc", 32'(PCSrcE), 32'd0);
    @(negedge clk);
    reset = 0;

    // Vector table. No register writes are in flight, so no operand is forwarded.
    for (int i = 0; i < 13; i++) begin
      ALUControlE = vt[i].op; rd1E = vt[i].a; rd2E = vt[i].b; ALUSrcE = vt[i].alusrc;
      ImmExtE = vt[i].imm; PCE = vt[i].pce; JumpE = vt[i].jump; BranchE = vt[i].branch;
      #1;
      chk($sformatf("vec%0d_pcsrc", i), 32'(PCSrcE), 32'(vt[i].exp_pcsrc));
      chk($sformatf("vec%0d_target", i), PCTargetE, vt[i].exp_tgt);
      tick();
      chk($sformatf("vec%0d_alu", i), ALUResultM, vt[i].exp_alu);
    end

    // All-zero bubble: this is a no-op.
    clear_in();
    chk_comb();
    chk("bubble_pcsrc", 32'(PCSrcE), 32'd0);
    tick();
    chk("bubble_regwrite", 32'(RegWriteM), 32'd0);
    chk("bubble_memwrite", 32'(MemWriteM), 32'd0);

    // Forward priority: M (10) wins over W (20). W is used once M no longer matches.
    clear_in();
    RegWriteE = 1; RdE = 5; ALUSrcE = 1; ImmExtE = 10;
    tick();
    Rs1E = 5; rd1E = 99; ImmExtE = 1; RdE = 6; RegWriteW = 1; RdW = 5; ResultW = 20;
    chk_comb();
    tick();
    chk("fwd_m_priority", ALUResultM, 32'd11);
    tick();
    chk("fwd_w", ALUResultM, 32'd21);

    // x0 guard: neither an M nor a W write to x0 forwards.
    clear_in();
    RegWriteE = 1; RdE = 0; ALUSrcE = 1; ImmExtE = 7;
    tick();
    chk("x0_setup", ALUResultM, 32'd7);
    clear_in();
    MemWriteE = 1; RegWriteW = 1; RdW = 0; ResultW = 55;
    tick();
    chk("x0_writedata", WriteDataM, 32'd0);
    chk("x0_memwrite", 32'(MemWriteM), 32'd1);

    // Hold: M freezes at 3 and the redirect is suppressed. Capture resumes afterwards.
    clear_in();
    RegWriteE = 1; RdE = 2; rd1E = 3;
    tick();
    chk("hold_setup", ALUResultM, 32'd3);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      JumpE = 1; rd1E = $urandom; RdE = 5'($urandom_range(1, 31)); PCPlus4E = $urandom;
      chk_comb();
      chk($sformatf("hold%0d_pcsrc", i), 32'(PCSrcE), 32'd0);
      tick();
      chk($sformatf("hold%0d_alu", i), ALUResultM, 32'd3);
    end
    hold = 0; JumpE = 0; rd1E = 4; Rs1E = 0;
    tick();
    chk("hold_release", ALUResultM, 32'd4);

    // ALU sweep with A = 0x80000000 and B = 1.
    clear_in();
    rd1E = 32'h80000000; rd2E = 1;
    ALUControlE = 3'd5; tick(); chk("sweep_slt", ALUResultM, 32'd1);
    ALUControlE = 3'd7; tick(); chk("sweep_srl", ALUResultM, 32'h40000000);
    ALUControlE = 3'd6; tick(); chk("sweep_sll", ALUResultM, 32'd0);
    ALUControlE = 3'd1; tick(); chk("sweep_sub", ALUResultM, 32'h7FFFFFFF);

    // JAL: the M stage forwards PC+4 rather than its ALU result.
    clear_in();
    JumpE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h204; RegWriteE = 1; RdE = 1;
    rd1E = 32'h55; PCE = 32'h200; ImmExtE = 32'h40;
    chk_comb();
    tick();
    chk("jal_pcplus4", PCPlus4M, 32'h204);
    clear_in();
    Rs1E = 1; Rs2E = 1; ALUSrcE = 1;
    tick();
    chk("jal_fwd_a", ALUResultM, 32'h204);
    chk("jal_fwd_b", WriteDataM, 32'h204);

    // Mid-cycle reset clears M immediately, including across an edge under hold.
    clear_in();
    RegWriteE = 1; RdE = 3; rd1E = 32'h1234;
    tick();
    chk("rst_setup", ALUResultM, 32'h1234);
    #2;
    reset = 1;
    #1;
    model_clear();
    chk_m();
    hold = 1; rd1E = 32'h77;
    tick();
    #2;
    reset = 0;
    clear_in();
    chk_comb();
    chk("rst_pcsrc_zero", 32'(PCSrcE), 32'd0);
    RegWriteE = 1; RdE = 4; rd1E = 9;
    tick();
    chk("rst_resume", ALUResultM, 32'd9);

    // Randomized traffic. Register indices are kept small so forwarding hits often.
    for (int i = 0; i < 400; i++) begin
      RegWriteE = 1'($urandom); ResultSrcE = 2'($urandom); MemWriteE = 1'($urandom);
      JumpE = ($urandom_range(0, 5) == 0); BranchE = 1'($urandom);
      ALUControlE = 3'($urandom); ALUSrcE = 1'($urandom);
      rd1E = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8)) : $urandom;
      rd2E = ($urandom_range(0, 2) == 0) ? rd1E : $urandom;
      PCE = $urandom; ImmExtE = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      PCPlus4E = $urandom;
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3)); RdE = 5'($urandom_range(0, 3));
      RegWriteW = 1'($urandom); RdW = 5'($urandom_range(0, 3)); ResultW = $urandom;
      hold = ($urandom_range(0, 4) == 0);
      chk_comb();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
